// File: rtl/picoblaze_irq_arbiter.sv
// picoblaze_irq_arbiter: round-robin sharing of the PicoBlaze interrupt among edge-triggered sources
module picoblaze_irq_arbiter #(
   parameter int         NUM_SRC     = 4,
   parameter logic [7:0] VECTOR_PORT = 8'h08,
   parameter logic [7:0] STATUS_PORT = 8'h09,
   parameter logic [7:0] MASK_PORT   = 8'h0A,
   parameter logic [7:0] EOI_PORT    = 8'h0B
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_src,
   output logic               interrupt,
   input  logic               interrupt_ack,
   input  logic [7:0]         port_id,
   input  logic               write_strobe,
   input  logic [7:0]         out_port,
   output logic [7:0]         rd_data,
   output logic [NUM_SRC-1:0] pending
);
   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
   state_t state_q, state_d;
   logic [NUM_SRC-1:0] sync1_q, sync2_q, prev_q, pending_q, pending_d, mask_q, mask_d, clr, avail;
   logic [2:0] grant_q, grant_d, rr_q, rr_d, idx;
   logic [7:0] rd_data_q, rd_data_d;
   logic interrupt_q, interrupt_d, found;
   int j;

   // first pending, enabled source at or above the pointer, wrapping around
   always_comb begin
      found = 1'b0;
      idx = '0;
      j = 0;
      avail = pending_q & mask_q;
      for (int k = 0; k < NUM_SRC; k++) begin
         j = int'(rr_q) + k;
         j = (j >= NUM_SRC) ? j - NUM_SRC : j;
         if (!found && |(avail & (NUM_SRC'(1) << j))) begin
            found = 1'b1;
            idx = 3'(j);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d = rr_q;
      interrupt_d = interrupt_q;
      clr = '0;
      mask_d = (write_strobe && port_id == MASK_PORT) ? out_port[NUM_SRC-1:0] : mask_q;
      case (state_q)
         IDLE: if (found) begin
            grant_d = idx;
            interrupt_d = 1'b1;
            state_d = REQ;
         end
         REQ: if (interrupt_ack) begin
            interrupt_d = 1'b0;
            clr = NUM_SRC'(1) << grant_q;
            rr_d = (grant_q == 3'(NUM_SRC - 1)) ? 3'd0 : grant_q + 3'd1;
            state_d = SERVICE;
         end
         SERVICE: if (write_strobe && port_id == EOI_PORT) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // a fresh edge wins over the acknowledge clear
      pending_d = (pending_q & ~clr) | (sync2_q & ~prev_q);
      rd_data_d = (port_id == VECTOR_PORT) ? {5'b0, grant_q} :
                  (port_id == STATUS_PORT) ? 8'(pending_q) :
                  (port_id == MASK_PORT)   ? 8'(mask_q) : 8'h00;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q <= '0;
         pending_q <= '0;
         mask_q <= '1;
         grant_q <= '0;
         rr_q <= '0;
         interrupt_q <= 1'b0;
         rd_data_q <= 8'h00;
         state_q <= IDLE;
      end else begin
         sync1_q <= irq_src;
         sync2_q <= sync1_q;
         prev_q <= sync2_q;
         pending_q <= pending_d;
         mask_q <= mask_d;
         grant_q <= grant_d;
         rr_q <= rr_d;
         interrupt_q <= interrupt_d;
         rd_data_q <= rd_data_d;
         state_q <= state_d;
      end
   end

   assign interrupt = interrupt_q;
   assign rd_data = rd_data_q;
   assign pending = pending_q;
endmodule

// File: tb/tb_picoblaze_irq_arbiter.sv
// tb_picoblaze_irq_arbiter: vector table plus hand-written sequences, checked through an expectation queue
module tb_picoblaze_irq_arbiter;
   logic clk = 1'b0, reset = 1'b0, interrupt, interrupt_ack = 1'b0, write_strobe = 1'b0;
   logic [3:0] irq_src = '0, pending;
   logic [7:0] port_id = '0, out_port = '0, rd_data;
   int n_vec = 0, n_err = 0;

   typedef struct {
      logic rst;
      logic [3:0] irq;
      logic ack, ws;
      logic [7:0] pid, od;
      logic [2:0] chk;
      logic e_int;
      logic [3:0] e_pend;
      logic [7:0] e_rd;
   } vec_t;

   vec_t tbl[14];
   vec_t exp_q[$];

   picoblaze_irq_arbiter dut (
      .clk(clk), .reset(reset), .irq_src(irq_src), .interrupt(interrupt),
      .interrupt_ack(interrupt_ack), .port_id(port_id), .write_strobe(write_strobe),
      .out_port(out_port), .rd_data(rd_data), .pending(pending)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic [3:0] i, input logic a, w,
                               input logic [7:0] p, o, input logic [2:0] c,
                               input logic ei, input logic [3:0] ep, input logic [7:0] er);
      vec_t v;
      v.rst = r; v.irq = i; v.ack = a; v.ws = w; v.pid = p; v.od = o;
      v.chk = c; v.e_int = ei; v.e_pend = ep; v.e_rd = er;
      return v;
   endfunction

   task automatic apply(input vec_t v);
      vec_t e;
      reset = v.rst; irq_src = v.irq; interrupt_ack = v.ack;
      write_strobe = v.ws; port_id = v.pid; out_port = v.od;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      if (e.chk[0]) begin
         n_vec++;
         if (interrupt !== e.e_int) begin
            n_err++;
            $display("FAIL interrupt @%0t: got %b want %b", $time, interrupt, e.e_int);
         end
      end
      if (e.chk[1]) begin
         n_vec++;
         if (pending !== e.e_pend) begin
            n_err++;
            $display("FAIL pending @%0t: got %h want %h", $time, pending, e.e_pend);
         end
      end
      if (e.chk[2]) begin
         n_vec++;
         if (rd_data !== e.e_rd) begin
            n_err++;
            $display("FAIL rd_data @%0t: got %h want %h", $time, rd_data, e.e_rd);
         end
      end
   endtask

   task automatic cyc(input logic r, input logic [3:0] i, input logic a, w,
                      input logic [7:0] p, o, input logic [2:0] c,
                      input logic ei, input logic [3:0] ep, input logic [7:0] er);
      apply(mk(r, i, a, w, p, o, c, ei, ep, er));
   endtask

   initial begin
      logic [3:0] ep;
      // single request on source 2, stray EOI and unmapped reads
      tbl[0]  = mk(1, 4'h0, 0, 0, 8'h00, 8'h00, 3'b111, 0, 4'h0, 8'h00);
      tbl[1]  = mk(0, 4'h4, 0, 0, 8'h00, 8'h00, 3'b111, 0, 4'h0, 8'h00);
      tbl[2]  = mk(0, 4'h0, 0, 0, 8'h00, 8'h00, 3'b011, 0, 4'h0, 8'h00);
      tbl[3]  = mk(0, 4'h0, 0, 0, 8'h00, 8'h00, 3'b011, 0, 4'h4, 8'h00);
      tbl[4]  = mk(0, 4'h0, 0, 0, 8'h00, 8'h00, 3'b011, 1, 4'h4, 8'h00);
      tbl[5]  = mk(0, 4'h0, 0, 0, 8'h00, 8'h00, 3'b011, 1, 4'h4, 8'h00);
      tbl[6]  = mk(0, 4'h0, 1, 0, 8'h08, 8'h00, 3'b111, 0, 4'h0, 8'h02);
      tbl[7]  = mk(0, 4'h0, 0, 0, 8'h09, 8'h00, 3'b111, 0, 4'h0, 8'h00);
      tbl[8]  = mk(0, 4'h0, 0, 1, 8'h0B, 8'h00, 3'b111, 0, 4'h0, 8'h00);
      tbl[9]  = mk(0, 4'h0, 0, 0, 8'h00, 8'h00, 3'b011, 0, 4'h0, 8'h00);
      tbl[10] = mk(0, 4'h0, 0, 1, 8'h0B, 8'h00, 3'b111, 0, 4'h0, 8'h00);
      tbl[11] = mk(0, 4'h0, 0, 0, 8'h55, 8'h00, 3'b111, 0, 4'h0, 8'h00);
      tbl[12] = mk(0, 4'h0, 0, 0, 8'h08, 8'h00, 3'b111, 0, 4'h0, 8'h02);
      tbl[13] = mk(0, 4'h0, 0, 0, 8'h0A, 8'h00, 3'b111, 0, 4'h0, 8'h0F);
      for (int i = 0; i < 14; i++) apply(tbl[i]);

      // round robin: all four raised together from pointer 0
      cyc(1, 4'h0, 0, 0, 8'h00, 8'h00, 3'b011, 0, 4'h0, 8'h00);
      cyc(0, 4'hF, 0, 0, 8'h00, 8'h00, 3'b011, 0, 4'h0, 8'h00);
      cyc(0, 4'hF, 0, 0, 8'h00, 8'h00, 3'b011, 0, 4'h0, 8'h00);
      cyc(0, 4'hF, 0, 0, 8'h00, 8'h00, 3'b011, 0, 4'hF, 8'h00);
      cyc(0, 4'hF, 0, 0, 8'h00, 8'h00, 3'b011, 1, 4'hF, 8'h00);
      for (int g = 0; g < 4; g++) begin
         ep = 4'(8'h0F << (g + 1));
         cyc(0, 4'hF, 1, 0, 8'h08, 8'h00, 3'b111, 0, ep, 8'(g));
         cyc(0, 4'hF, 0, 1, 8'h0B, 8'h00, 3'b011, 0, ep, 8'h00);
         cyc(0, 4'hF, 0, 0, 8'h00, 8'h00, 3'b001, g < 3, ep, 8'h00);
      end
      for (int i = 0; i < 3; i++) cyc(0, 4'h0, 0, 0, 8'h00, 8'h00, 3'b011, 0, 4'h0, 8'h00);
      cyc(0, 4'h9, 0, 0, 8'h00, 8'h00, 3'b011, 0, 4'h0, 8'h00);
      cyc(0, 4'h9, 0, 0, 8'h00, 8'h00, 3'b011, 0, 4'h0, 8'h00);
      cyc(0, 4'h9, 0, 0, 8'h00, 8'h00, 3'b011, 0, 4'h9, 8'h00);
      cyc(0, 4'h9, 0, 0, 8'h00, 8'h00, 3'b011, 1, 4'h9, 8'h00);
      cyc(0, 4'h9, 1, 0, 8'h08, 8'h00, 3'b111, 0, 4'h8, 8'h00);
      cyc(0, 4'h9, 0, 1, 8'h0B, 8'h00, 3'b001, 0, 4'h0, 8'h00);
      cyc(0, 4'h9, 0, 0, 8'h00, 8'h00, 3'b001, 1, 4'h0, 8'h00);
      cyc(0, 4'h9, 1, 0, 8'h08, 8'h00, 3'b111, 0, 4'h0, 8'h03);
      cyc(0, 4'h9, 0, 1, 8'h0B, 8'h00, 3'b001, 0, 4'h0, 8'h00);

      // masking: source 2 disabled, then re-enabled
      for (int i = 0; i < 3; i++) cyc(0, 4'h0, 0, 0, 8'h00, 8'h00, 3'b011, 0, 4'h0, 8'h00);
      cyc(0, 4'h0, 0, 1, 8'h0A, 8'h0B, 3'b011, 0, 4'h0, 8'h00);
      cyc(0, 4'h0, 0, 0, 8'h0A, 8'h00, 3'b111, 0, 4'h0, 8'h0B);
      cyc(0, 4'h4, 0, 0, 8'h00, 8'h00, 3'b011, 0, 4'h0, 8'h00);
      cyc(0, 4'h4, 0, 0, 8'h00, 8'h00, 3'b011, 0, 4'h0, 8'h00);
      cyc(0, 4'h4, 0, 0, 8'h00, 8'h00, 3'b011, 0, 4'h4, 8'h00);
      cyc(0, 4'h4, 0, 0, 8'h09, 8'h00, 3'b111, 0, 4'h4, 8'h04);
      cyc(0, 4'h4, 0, 0, 8'h00, 8'h00, 3'b011, 0, 4'h4, 8'h00);
      cyc(0, 4'h4, 0, 1, 8'h0A, 8'h0F, 3'b011, 0, 4'h4, 8'h00);
      cyc(0, 4'h4, 0, 0, 8'h00, 8'h00, 3'b011, 1, 4'h4, 8'h00);
      cyc(0, 4'h4, 0, 0, 8'h08, 8'h00, 3'b111, 1, 4'h4, 8'h02);

      // collision: new edge on the granted source lands with the ack
      for (int i = 0; i < 3; i++) cyc(0, 4'h0, 0, 0, 8'h00, 8'h00, 3'b011, 1, 4'h4, 8'h00);
      cyc(0, 4'h4, 0, 0, 8'h00, 8'h00, 3'b011, 1, 4'h4, 8'h00);
      cyc(0, 4'h4, 0, 0, 8'h00, 8'h00, 3'b011, 1, 4'h4, 8'h00);
      cyc(0, 4'h4, 1, 0, 8'h08, 8'h00, 3'b111, 0, 4'h4, 8'h02);
      cyc(0, 4'h4, 0, 1, 8'h0B, 8'h00, 3'b011, 0, 4'h4, 8'h00);
      cyc(0, 4'h4, 0, 0, 8'h00, 8'h00, 3'b011, 1, 4'h4, 8'h00);
      cyc(0, 4'h4, 0, 0, 8'h08, 8'h00, 3'b111, 1, 4'h4, 8'h02);

      // reset while in service with two sources pending
      cyc(0, 4'h4, 1, 0, 8'h00, 8'h00, 3'b011, 0, 4'h0, 8'h00);
      for (int i = 0; i < 3; i++) cyc(0, 4'h0, 0, 0, 8'h00, 8'h00, 3'b011, 0, 4'h0, 8'h00);
      cyc(0, 4'h3, 0, 0, 8'h00, 8'h00, 3'b011, 0, 4'h0, 8'h00);
      cyc(0, 4'h3, 0, 0, 8'h00, 8'h00, 3'b011, 0, 4'h0, 8'h00);
      cyc(0, 4'h3, 0, 0, 8'h00, 8'h00, 3'b011, 0, 4'h3, 8'h00);
      cyc(0, 4'h3, 0, 0, 8'h00, 8'h00, 3'b011, 0, 4'h3, 8'h00);
      cyc(1, 4'h0, 0, 0, 8'h0A, 8'h00, 3'b111, 0, 4'h0, 8'h00);
      cyc(0, 4'h0, 0, 0, 8'h0A, 8'h00, 3'b111, 0, 4'h0, 8'h0F);
      for (int i = 0; i < 4; i++) cyc(0, 4'h0, 0, 0, 8'h00, 8'h00, 3'b011, 0, 4'h0, 8'h00);
      cyc(0, 4'h2, 0, 0, 8'h00, 8'h00, 3'b011, 0, 4'h0, 8'h00);
      cyc(0, 4'h2, 0, 0, 8'h00, 8'h00, 3'b011, 0, 4'h0, 8'h00);
      cyc(0, 4'h2, 0, 0, 8'h00, 8'h00, 3'b011, 0, 4'h2, 8'h00);
      cyc(0, 4'h2, 0, 0, 8'h00, 8'h00, 3'b011, 1, 4'h2, 8'h00);
      cyc(0, 4'h2, 1, 0, 8'h08, 8'h00, 3'b111, 0, 4'h0, 8'h01);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
